// File: rtl/pixel_scheduler.sv
`timescale 1ns/1ps
// Pixel scheduler: walks an H_RES x V_RES raster in order, handing one coordinate at a time
// to an iteration engine and forwarding each engine result on a valid/ready stream.
module pixel_scheduler #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int COORD_WIDTH = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          start,
    input  logic                          abort,
    input  logic signed [COORD_WIDTH-1:0] center_x,
    input  logic signed [COORD_WIDTH-1:0] center_y,
    input  logic [7:0]                    zoom_level,
    input  logic [5:0]                    max_iter_limit,
    output logic signed [COORD_WIDTH-1:0] p_center_x,
    output logic signed [COORD_WIDTH-1:0] p_center_y,
    output logic [7:0]                    p_zoom_level,
    output logic [5:0]                    p_max_iter,
    output logic [9:0]                    pixel_x,
    output logic [9:0]                    pixel_y,
    output logic                          pixel_valid,
    input  logic [5:0]                    eng_iter,
    input  logic                          eng_result_valid,
    input  logic                          eng_busy,
    output logic [9:0]                    out_x,
    output logic [9:0]                    out_y,
    output logic [5:0]                    out_iter,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_done,
    output logic                          busy,
    output logic [7:0]                    frame_count
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_REL = 2'd2,
        OUTPUT   = 2'd3
    } state_e;

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    state_e                  state_q, state_d;
    logic signed [COORD_WIDTH-1:0] p_cx_q, p_cx_d, p_cy_q, p_cy_d;
    logic [7:0]              p_zoom_q, p_zoom_d;
    logic [5:0]              p_iter_q, p_iter_d;
    logic [9:0]              pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic                    pixel_valid_q, pixel_valid_d;
    logic [9:0]              out_x_q, out_x_d, out_y_q, out_y_d;
    logic [5:0]              out_iter_q, out_iter_d;
    logic                    out_valid_q, out_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    busy_q, busy_d;
    logic [7:0]              frame_count_q, frame_count_d;

    // Next-state and next-output logic; abort overrides enable, which overrides the FSM
    always_comb begin
        state_d       = state_q;
        p_cx_d        = p_cx_q;
        p_cy_d        = p_cy_q;
        p_zoom_d      = p_zoom_q;
        p_iter_d      = p_iter_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        pixel_valid_d = pixel_valid_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        out_iter_d    = out_iter_q;
        out_valid_d   = out_valid_q;
        frame_done_d  = frame_done_q;
        frame_count_d = frame_count_q;

        if (abort) begin
            state_d       = IDLE;
            pixel_valid_d = 1'b0;
            out_valid_d   = 1'b0;
            frame_done_d  = 1'b0;
        end else if (enable) begin
            frame_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !eng_busy) begin
                        p_cx_d        = center_x;
                        p_cy_d        = center_y;
                        p_zoom_d      = zoom_level;
                        p_iter_d      = max_iter_limit;
                        pixel_x_d     = 10'd0;
                        pixel_y_d     = 10'd0;
                        pixel_valid_d = 1'b1;
                        state_d       = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ISSUE: begin
                    if (eng_result_valid) begin
                        out_iter_d    = eng_iter;
                        out_x_d       = pixel_x_q;
                        out_y_d       = pixel_y_q;
                        pixel_valid_d = 1'b0;
                        state_d       = WAIT_REL;
                    end else begin
                        state_d = ISSUE;
                    end
                end
                WAIT_REL: begin
                    if (!eng_busy) begin
                        out_valid_d = 1'b1;
                        state_d     = OUTPUT;
                    end else begin
                        state_d = WAIT_REL;
                    end
                end
                OUTPUT: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        // The transferred result always carries the current pixel coordinate
                        if (pixel_x_q == X_LAST) begin
                            pixel_x_d = 10'd0;
                            if (pixel_y_q == Y_LAST) begin
                                frame_done_d  = 1'b1;
                                frame_count_d = frame_count_q + 8'd1;
                                state_d       = IDLE;
                            end else begin
                                pixel_y_d     = pixel_y_q + 10'd1;
                                pixel_valid_d = 1'b1;
                                state_d       = ISSUE;
                            end
                        end else begin
                            pixel_x_d     = pixel_x_q + 10'd1;
                            pixel_valid_d = 1'b1;
                            state_d       = ISSUE;
                        end
                    end else begin
                        state_d = OUTPUT;
                    end
                end
                default: begin
                    state_d       = IDLE;
                    pixel_valid_d = 1'b0;
                    out_valid_d   = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            p_cx_q        <= {COORD_WIDTH{1'b0}};
            p_cy_q        <= {COORD_WIDTH{1'b0}};
            p_zoom_q      <= 8'd0;
            p_iter_q      <= 6'd0;
            pixel_x_q     <= 10'd0;
            pixel_y_q     <= 10'd0;
            pixel_valid_q <= 1'b0;
            out_x_q       <= 10'd0;
            out_y_q       <= 10'd0;
            out_iter_q    <= 6'd0;
            out_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            p_cx_q        <= p_cx_d;
            p_cy_q        <= p_cy_d;
            p_zoom_q      <= p_zoom_d;
            p_iter_q      <= p_iter_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_valid_q <= pixel_valid_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            out_iter_q    <= out_iter_d;
            out_valid_q   <= out_valid_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign p_center_x   = p_cx_q;
    assign p_center_y   = p_cy_q;
    assign p_zoom_level = p_zoom_q;
    assign p_max_iter   = p_iter_q;
    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign pixel_valid  = pixel_valid_q;
    assign out_x        = out_x_q;
    assign out_y        = out_y_q;
    assign out_iter     = out_iter_q;
    assign out_valid    = out_valid_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
`timescale 1ns/1ps
// Bench for pixel_scheduler on a 4x2 raster with a behavioural engine (iter = x + 2y after 3 cycles);
// a raster-order reference model checks the result stream every cycle alongside directed scenarios.
module tb_pixel_scheduler;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int CW = 11;

    logic clk;
    logic rst_n, enable, start, abort, out_ready;
    logic signed [CW-1:0] center_x, center_y, p_center_x, p_center_y;
    logic [7:0] zoom_level, p_zoom_level, frame_count;
    logic [5:0] max_iter_limit, p_max_iter, eng_iter, out_iter;
    logic [9:0] pixel_x, pixel_y, out_x, out_y;
    logic pixel_valid, eng_result_valid, eng_busy, out_valid, frame_done, busy;

    int vectors = 0;
    int miscompares = 0;
    int extra_cfg = 0;
    int xfer_total = 0;

    // engine state
    int est, ecnt, eext;
    logic [9:0] ex, ey;

    // reference model state
    int exp_idx, issue_idx, fc_m;
    logic m_active, fd_exp, hold_exp, abort_seen, pv_prev, xfer;
    logic [9:0] hx, hy;
    logic [5:0] hi;
    logic signed [CW-1:0] pm_cx, pm_cy;
    logic [7:0] pm_zoom;
    logic [5:0] pm_iter;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pixel_scheduler #(.H_RES(H), .V_RES(V), .COORD_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .abort(abort),
        .center_x(center_x), .center_y(center_y), .zoom_level(zoom_level),
        .max_iter_limit(max_iter_limit),
        .p_center_x(p_center_x), .p_center_y(p_center_y), .p_zoom_level(p_zoom_level),
        .p_max_iter(p_max_iter),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
        .eng_iter(eng_iter), .eng_result_valid(eng_result_valid), .eng_busy(eng_busy),
        .out_x(out_x), .out_y(out_y), .out_iter(out_iter), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done), .busy(busy), .frame_count(frame_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic bit cond_met(input int which);
        case (which)
            0: return !busy;
            1: return busy && !pixel_valid && !out_valid;
            2: return out_valid;
            3: return pixel_valid && pixel_x == 10'd1 && pixel_y == 10'd0;
            4: return busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int which, input int budget, input string name);
        int n = 0;
        while (!cond_met(which) && n < budget) begin
            cyc(1);
            n++;
        end
        chk(name, {31'd0, cond_met(which)}, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_pixel_valid"}, pixel_valid, 32'd0);
        chk({tag, "_out_valid"}, out_valid, 32'd0);
        chk({tag, "_frame_done"}, frame_done, 32'd0);
        chk({tag, "_pixel_x"}, pixel_x, 32'd0);
        chk({tag, "_pixel_y"}, pixel_y, 32'd0);
        chk({tag, "_out_x"}, out_x, 32'd0);
        chk({tag, "_out_y"}, out_y, 32'd0);
        chk({tag, "_out_iter"}, out_iter, 32'd0);
        chk({tag, "_frame_count"}, frame_count, 32'd0);
        chk({tag, "_p_center_x"}, p_center_x, 32'd0);
        chk({tag, "_p_center_y"}, p_center_y, 32'd0);
        chk({tag, "_p_zoom"}, p_zoom_level, 32'd0);
        chk({tag, "_p_max_iter"}, p_max_iter, 32'd0);
    endtask

    // Behavioural engine: accepts a pixel, answers after 3 cycles, holds the result until
    // the request drops, then stays busy for extra_cfg more cycles.
    initial begin
        est = 0; ecnt = 0; eext = 0; ex = 10'd0; ey = 10'd0;
        eng_busy = 1'b0; eng_result_valid = 1'b0; eng_iter = 6'd0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                est = 0; eng_busy = 1'b0; eng_result_valid = 1'b0;
            end else begin
                case (est)
                    0: if (pixel_valid) begin
                        ex = pixel_x; ey = pixel_y; eng_busy = 1'b1; ecnt = 1; est = 1;
                    end
                    1: begin
                        ecnt++;
                        if (ecnt == 3) begin
                            eng_result_valid = 1'b1;
                            eng_iter = 6'(ex + 10'd2 * ey);
                            est = 2;
                        end
                    end
                    2: if (!pixel_valid) begin
                        eng_result_valid = 1'b0;
                        if (extra_cfg > 0) begin eext = extra_cfg; est = 3; end
                        else begin eng_busy = 1'b0; est = 0; end
                    end
                    default: begin
                        eext--;
                        if (eext == 0) begin eng_busy = 1'b0; est = 0; end
                    end
                endcase
            end
        end
    end

    // Reference model and per-cycle compare, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_idx = 0; issue_idx = 0; fc_m = 0; m_active = 1'b0;
                fd_exp = 1'b0; hold_exp = 1'b0; abort_seen = 1'b0; pv_prev = 1'b0;
                pm_cx = '0; pm_cy = '0; pm_zoom = 8'd0; pm_iter = 6'd0;
            end else begin
                if (abort_seen) begin
                    chk("abort_pixel_valid", pixel_valid, 32'd0);
                    chk("abort_out_valid", out_valid, 32'd0);
                end
                if (hold_exp) begin
                    chk("hold_out_valid", out_valid, 32'd1);
                    chk("hold_out_x", out_x, hx);
                    chk("hold_out_y", out_y, hy);
                    chk("hold_out_iter", out_iter, hi);
                end
                chk("busy", busy, m_active);
                chk("frame_done", frame_done, fd_exp);
                chk("frame_count", frame_count, fc_m);
                chk("p_center_x", p_center_x, pm_cx);
                chk("p_center_y", p_center_y, pm_cy);
                chk("p_zoom_level", p_zoom_level, pm_zoom);
                chk("p_max_iter", p_max_iter, pm_iter);
                chk("valid_overlap", pixel_valid & out_valid, 32'd0);
                if (pixel_valid && !pv_prev) begin
                    chk("issue_x", pixel_x, issue_idx % H);
                    chk("issue_y", pixel_y, issue_idx / H);
                    issue_idx++;
                end
                pv_prev = pixel_valid;

                xfer = enable && !abort && out_valid && out_ready;
                if (xfer) begin
                    chk("xfer_x", out_x, exp_idx % H);
                    chk("xfer_y", out_y, exp_idx / H);
                    chk("xfer_iter", out_iter, (exp_idx % H) + 2 * (exp_idx / H));
                    xfer_total++;
                end
                abort_seen = abort;
                hold_exp = out_valid && !xfer && !abort;
                hx = out_x; hy = out_y; hi = out_iter;
                if (abort) fd_exp = 1'b0;
                else if (enable) fd_exp = xfer && (exp_idx == H * V - 1);
                if (xfer) begin
                    if (exp_idx == H * V - 1) begin
                        exp_idx = 0; fc_m = (fc_m + 1) % 256; m_active = 1'b0;
                    end else begin
                        exp_idx++;
                    end
                end
                if (abort) begin
                    m_active = 1'b0;
                end else if (enable && start && !m_active && !eng_busy) begin
                    m_active = 1'b1; exp_idx = 0; issue_idx = 0;
                    pm_cx = center_x; pm_cy = center_y; pm_zoom = zoom_level; pm_iter = max_iter_limit;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Directed scenarios
    initial begin
        rst_n = 1'b0; enable = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        center_x = '0; center_y = '0; zoom_level = 8'd0; max_iter_limit = 6'd0;
        cyc(3);
        chk_reset("por");
        rst_n = 1'b1;

        // start ignored until enable is high, then a full frame with ready always high
        start = 1'b1; center_x = -11'sd128; center_y = 11'sd5; zoom_level = 8'd3;
        max_iter_limit = 6'd20; out_ready = 1'b1;
        cyc(2);
        chk("start_needs_enable", busy, 32'd0);
        enable = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("f1_busy", busy, 32'd1);
        chk("f1_first_issue", pixel_valid, 32'd1);
        wait_until(0, 200, "f1_end");
        chk("f1_frame_count", frame_count, 32'd1);
        chk("f1_p_center_x", p_center_x, -128);
        chk("f1_xfers", xfer_total, 32'd8);
        chk("f1_last_x", out_x, 32'd3);
        chk("f1_last_y", out_y, 32'd1);
        chk("f1_last_iter", out_iter, 32'd5);

        // backpressure on pixel (1,0)
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_until(3, 60, "bp_issue_1_0");
        out_ready = 1'b0;
        wait_until(2, 60, "bp_out_valid_rise");
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 32'd1);
            chk("bp_out_x", out_x, 32'd1);
            chk("bp_out_iter", out_iter, 32'd1);
            chk("bp_pixel_valid", pixel_valid, 32'd0);
            if (i < 4) cyc(1);
        end
        out_ready = 1'b1;
        cyc(1);
        chk("bp_next_valid", pixel_valid, 32'd1);
        chk("bp_next_x", pixel_x, 32'd2);
        chk("bp_next_y", pixel_y, 32'd0);
        wait_until(0, 200, "f2_end");
        chk("f2_frame_count", frame_count, 32'd2);

        // enable low for 4 cycles while issuing (0,0)
        center_y = -11'sd7;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("frz_pixel_valid", pixel_valid, 32'd1);
            chk("frz_pixel_x", pixel_x, 32'd0);
            chk("frz_pixel_y", pixel_y, 32'd0);
            chk("frz_busy", busy, 32'd1);
            chk("frz_out_valid", out_valid, 32'd0);
        end
        enable = 1'b1;
        wait_until(0, 200, "f3_end");
        chk("f3_frame_count", frame_count, 32'd3);
        chk("f3_p_center_y", p_center_y, -7);

        // abort in WAIT_REL while the engine stays busy; start with abort loses
        extra_cfg = 8; center_x = 11'sd100; zoom_level = 8'd7;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_until(1, 50, "ab_reach_wait_rel");
        abort = 1'b1; start = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("ab_busy", busy, 32'd0);
        chk("ab_pixel_valid", pixel_valid, 32'd0);
        chk("ab_out_valid", out_valid, 32'd0);
        chk("ab_frame_done", frame_done, 32'd0);
        chk("ab_frame_count", frame_count, 32'd3);
        extra_cfg = 0; center_x = -11'sd5; zoom_level = 8'd9;
        cyc(2);
        chk("ab_start_ignored", busy, 32'd0);
        chk("ab_p_zoom_hold", p_zoom_level, 32'd7);
        wait_until(4, 30, "ab_restart");
        start = 1'b0;
        chk("ab_p_zoom_new", p_zoom_level, 32'd9);
        chk("ab_p_center_x_new", p_center_x, -5);
        wait_until(0, 200, "f4_end");
        chk("f4_frame_count", frame_count, 32'd4);

        // start pulses and parameter changes mid-frame
        zoom_level = 8'd11;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(10);
        start = 1'b1; zoom_level = 8'd99; center_x = 11'sd33;
        cyc(3);
        start = 1'b0;
        chk("mid_p_zoom", p_zoom_level, 32'd11);
        wait_until(0, 200, "f5_end");
        chk("f5_frame_count", frame_count, 32'd5);
        chk("f5_p_zoom", p_zoom_level, 32'd11);
        chk("f5_xfers", xfer_total, 32'd40);

        // asynchronous reset while issuing
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("post_reset_frame_count", frame_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 Parameters SHALL be: H_RES, default 640, pixels per line; V_RES, default 480, lines per frame; COORD_WIDTH, default 11, parameter word width.
REQ-002 Clock port SHALL be clk, input, 1 bit; rising-edge clock.
REQ-003 Reset port SHALL be rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 Port enable SHALL be input, 1 bit; global advance qualifier.
REQ-005 Port start SHALL be input, 1 bit; frame start request.
REQ-006 Port abort SHALL be input, 1 bit; synchronous frame cancel.
REQ-007 Ports center_x and center_y SHALL be input, COORD_WIDTH bits signed; view centre.
REQ-008 Port zoom_level SHALL be input, 8 bits; max_iter_limit SHALL be input, 6 bits.
REQ-009 Ports p_center_x, p_center_y, p_zoom_level and p_max_iter SHALL be outputs, same widths as REQ-007/008; frame-latched copies fed to the engine.
REQ-010 Ports pixel_x and pixel_y SHALL be outputs, 10 bits each; current coordinate to the engine.
REQ-011 Port pixel_valid SHALL be output, 1 bit; engine start/hold request.
REQ-012 Ports eng_iter (input, 6 bits), eng_result_valid (input, 1 bit) and eng_busy (input, 1 bit) SHALL carry engine results and status.
REQ-013 Ports out_x and out_y (output, 10 bits), out_iter (output, 6 bits), out_valid (output, 1 bit) and out_ready (input, 1 bit) SHALL form the downstream result stream.
REQ-014 Port frame_done SHALL be output, 1 bit; one-cycle end-of-frame pulse.
REQ-015 Port busy SHALL be output, 1 bit; high whenever the state is not IDLE.
REQ-016 Port frame_count SHALL be output, 8 bits; completed-frame counter.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT_REL, OUTPUT; all outputs SHALL be registered.
REQ-018 When enable=0, state, counters and all outputs SHALL hold, except that abort still acts.
REQ-019 IDLE: start=1 with eng_busy=0 SHALL latch the REQ-007/008 inputs into p_*, set pixel_x=0 and pixel_y=0, and enter ISSUE; start with eng_busy=1 SHALL be ignored.
REQ-020 ISSUE: pixel_valid=1 from the first ISSUE cycle; on eng_result_valid=1, eng_iter SHALL be captured into out_iter, pixel_x/pixel_y into out_x/out_y, pixel_valid cleared the next cycle, and the state SHALL become WAIT_REL.
REQ-021 WAIT_REL: pixel_valid=0; when eng_busy=0 the state SHALL become OUTPUT.
REQ-022 OUTPUT: out_valid=1 with out_x/out_y/out_iter stable until the transfer cycle (out_valid=1 and out_ready=1); on transfer out_valid SHALL clear the next cycle.
REQ-023 Coordinate advance on transfer: pixel_x+1; when pixel_x=H_RES-1, pixel_x SHALL wrap to 0 and pixel_y SHALL increment.
REQ-024 Transfer of (H_RES-1, V_RES-1) SHALL pulse frame_done for exactly one cycle, increment frame_count (wrapping 255 to 0) and enter IDLE; any other transfer SHALL enter ISSUE.
REQ-025 start in any state other than IDLE SHALL be ignored; p_* SHALL change only on an accepted start.
REQ-026 abort=1 in any state SHALL, next cycle, enter IDLE with pixel_valid=0 and out_valid=0, leave frame_done low and leave frame_count unchanged; abort has priority over start in the same cycle.
REQ-027 eng_result_valid outside ISSUE SHALL be ignored.
REQ-028 No pixel SHALL be issued twice or skipped; output order SHALL be raster order.

Reset
REQ-029 While rst_n=0: state=IDLE; pixel_x, pixel_y, out_x, out_y, out_iter, p_*, frame_count=0; pixel_valid, out_valid, frame_done, busy=0.
REQ-030 After rst_n deasserts, the first accepted start SHALL require an enable=1 cycle.

Verification (H_RES=4, V_RES=2, behavioural engine returning iter=x+2y after 3 cycles)
REQ-031 Reset: assert rst_n=0 mid-ISSUE -> all REQ-029 values the same cycle, asynchronously.
REQ-032 Full frame, out_ready=1: start with center_x=-128 -> 8 transfers (0,0,0)..(3,1,5) in raster order; frame_done one pulse after the (3,1) transfer; frame_count=1; p_center_x=-128.
REQ-033 Backpressure: out_ready=0 for 5 cycles at (1,0) -> out_valid=1, out_iter=1 held stable, pixel_valid=0 throughout; transfer on ready, then ISSUE at (2,0).
REQ-034 enable=0 for 4 cycles in ISSUE -> pixel_valid, coordinates and state frozen; resumes identically.
REQ-035 abort in WAIT_REL with eng_busy=1 -> IDLE next cycle; start ignored until eng_busy=0, then accepted with new p_* values.
REQ-036 start pulses and zoom_level changes mid-frame -> no restart; p_zoom_level unchanged until the next accepted start.
